// File: rtl/mmu_paged.sv
// mmu_paged: 6809 paged MMU with internal map table, per-page write protect,
// sticky first-fault capture with FIRQ and a delayed user-task switch.
module mmu_paged #(
    parameter int          PAGE_BITS    = 3,
    parameter int          TASK_BITS    = 5,
    parameter int          PHYS_BITS    = 7,
    parameter logic [15:0] REG_BASE     = 16'hFE10,
    parameter logic [15:0] MAP_BASE     = 16'hFE20,
    parameter logic [15:0] IO_MIN       = 16'hFC00,
    parameter logic [15:0] IO_MAX       = 16'hFEFF,
    parameter int          SWITCH_DELAY = 1
) (
    input  logic                 E,
    input  logic                 RESET,
    input  logic [15:0]          ADDR,
    input  logic                 RnW,
    input  logic                 BA,
    input  logic                 BS,
    input  logic [7:0]           DATA_IN,
    output logic [7:0]           DATA_OUT,
    output logic                 DATA_OE,
    output logic [PHYS_BITS-1:0] PPAGE,
    output logic                 IO_SEL,
    output logic                 nWR_PHYS,
    output logic                 nFIRQ,
    output logic                 USER
);
    localparam int IW = TASK_BITS + PAGE_BITS;
    localparam int NE = 1 << IW;

    logic [PHYS_BITS:0]   r_map [NE];
    logic                 r_enmmu, r_protect, r_irq_en, r_u, r_fault, r_armed;
    logic [TASK_BITS-1:0] r_access_key, r_task_key, r_fault_task;
    logic [7:0]           r_fault_addr, r_fault_count;
    logic [3:0]           r_switch_cnt;

    logic                 w_vector, w_hw_en, w_reg_hit, w_map_hit, w_wp_block;
    logic                 w_wr_reg, w_rti_rd, w_fault_clr;
    logic [PAGE_BITS-1:0] w_page;
    logic [TASK_BITS-1:0] w_task;
    logic [PHYS_BITS:0]   w_entry, w_map_rd;
    logic [7:0]           w_reg_data;

    assign w_vector    = !BA & BS & RnW;
    assign w_hw_en     = !r_enmmu | !r_u | !r_protect;
    assign w_page      = ADDR[15:16-PAGE_BITS];
    assign w_task      = (r_u & !w_vector) ? r_task_key : '0;
    assign w_entry     = r_map[{w_task, w_page}];
    assign w_map_rd    = r_map[{r_access_key, ADDR[PAGE_BITS-1:0]}];
    assign w_reg_hit   = w_hw_en & (ADDR[15:3] == REG_BASE[15:3]);
    assign w_map_hit   = w_hw_en & (ADDR[15:PAGE_BITS] == MAP_BASE[15:PAGE_BITS]);
    assign IO_SEL      = w_hw_en & (ADDR >= IO_MIN) & (ADDR <= IO_MAX);
    assign w_wp_block  = r_enmmu & r_u & !w_vector & w_entry[PHYS_BITS] & !RnW & !IO_SEL;
    assign w_wr_reg    = w_reg_hit & !RnW;
    assign w_rti_rd    = w_reg_hit & RnW & (ADDR[2:0] == 3'd3);
    assign w_fault_clr = w_wr_reg & (ADDR[2:0] == 3'd4);

    assign PPAGE    = r_enmmu ? w_entry[PHYS_BITS-1:0] : PHYS_BITS'(w_page);
    assign nWR_PHYS = !(E & !RnW & !w_wp_block);
    assign DATA_OE  = E & RnW & (w_reg_hit | w_map_hit);
    assign nFIRQ    = !(r_fault & r_irq_en);
    assign USER     = r_u;
    assign DATA_OUT = w_reg_hit ? w_reg_data :
                      w_map_hit ? {w_map_rd[PHYS_BITS], 7'(w_map_rd[PHYS_BITS-1:0])} : 8'h00;

    always_comb begin
        case (ADDR[2:0])
            3'd0:    w_reg_data = {3'b000, r_fault, !r_u, r_irq_en, r_protect, r_enmmu};
            3'd1:    w_reg_data = 8'(r_access_key);
            3'd2:    w_reg_data = 8'(r_task_key);
            3'd3:    w_reg_data = 8'h3B;
            3'd4:    w_reg_data = r_fault_addr;
            3'd5:    w_reg_data = 8'(r_fault_task);
            3'd6:    w_reg_data = r_fault_count;
            default: w_reg_data = 8'h00;
        endcase
    end

    // The map table survives reset so a warm restart keeps its page tables.
    always_ff @(negedge E) begin
        if (w_map_hit && !RnW)
            r_map[{r_access_key, ADDR[PAGE_BITS-1:0]}] <= {DATA_IN[7], DATA_IN[PHYS_BITS-1:0]};
    end

    always_ff @(negedge E or posedge RESET) begin
        if (RESET) begin
            r_enmmu       <= 1'b0;
            r_protect     <= 1'b0;
            r_irq_en      <= 1'b0;
            r_access_key  <= '0;
            r_task_key    <= '0;
            r_u           <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_addr  <= 8'h00;
            r_fault_task  <= '0;
            r_fault_count <= 8'h00;
            r_switch_cnt  <= 4'd0;
            r_armed       <= 1'b0;
        end else begin
            if (w_wr_reg && ADDR[2:0] == 3'd0)
                {r_irq_en, r_protect, r_enmmu} <= DATA_IN[2:0];
            if (w_wr_reg && ADDR[2:0] == 3'd1)
                r_access_key <= DATA_IN[TASK_BITS-1:0];
            if (w_wr_reg && ADDR[2:0] == 3'd2)
                r_task_key <= DATA_IN[TASK_BITS-1:0];
            // A clear on the same edge as a new fault lets the new fault become the first one.
            if (w_wp_block && (w_fault_clr || !r_fault)) begin
                r_fault      <= 1'b1;
                r_fault_addr <= ADDR[15:8];
                r_fault_task <= r_task_key;
            end else if (w_fault_clr) begin
                r_fault      <= 1'b0;
                r_fault_addr <= 8'h00;
                r_fault_task <= '0;
            end
            if (w_wr_reg && ADDR[2:0] == 3'd6)
                r_fault_count <= 8'h00;
            else if (w_wp_block && r_fault_count != 8'hFF)
                r_fault_count <= r_fault_count + 8'd1;
            if (w_vector) begin
                r_u     <= 1'b0;
                r_armed <= 1'b0;
            end else if (w_rti_rd && !r_u) begin
                r_u          <= (SWITCH_DELAY == 0);
                r_armed      <= (SWITCH_DELAY != 0);
                r_switch_cnt <= 4'(SWITCH_DELAY);
            end else if (r_armed) begin
                r_switch_cnt <= r_switch_cnt - 4'd1;
                if (r_switch_cnt == 4'd1) begin
                    r_u     <= 1'b1;
                    r_armed <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mmu_paged.sv
// tb_mmu_paged: directed plus random bus cycles on two MMUs (switch delay 1 and 3)
// checked against a behavioural model of the page map, fault and task-switch rules.
module tb_mmu_paged;
    logic        E = 1'b0, RESET = 1'b1, RnW = 1'b1, BA = 1'b0, BS = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [7:0]  DATA_IN = 8'h00;
    logic [7:0]  a_dout, b_dout;
    logic [6:0]  a_pp, b_pp;
    logic        a_doe, a_io, a_nwr, a_nfirq, a_user;
    logic        b_doe, b_io, b_nwr, b_nfirq, b_user;

    int checks = 0, errs = 0, edge_no = 0;
    int dly [2] = '{1, 3};
    bit m_en [2], m_prot [2], m_irq [2], m_u [2], m_fault [2];
    int m_akey [2], m_tkey [2], m_fa [2], m_ft [2], m_fc [2], m_due [2];
    logic [7:0]  mm [2][256];
    logic [31:0] x_pp [2], x_io [2], x_nwr [2], x_doe [2], x_dout [2], x_nfirq [2], x_user [2];
    logic [31:0] x_reg [2], x_map [2], x_wp [2];
    logic [31:0] o_pp [2], o_io [2], o_nwr [2], o_doe [2], o_dout [2], o_nfirq [2], o_user [2];
    bit x_vec;

    mmu_paged #(.SWITCH_DELAY(1)) u_a (
        .E(E), .RESET(RESET), .ADDR(ADDR), .RnW(RnW), .BA(BA), .BS(BS), .DATA_IN(DATA_IN),
        .DATA_OUT(a_dout), .DATA_OE(a_doe), .PPAGE(a_pp), .IO_SEL(a_io),
        .nWR_PHYS(a_nwr), .nFIRQ(a_nfirq), .USER(a_user)
    );
    mmu_paged #(.SWITCH_DELAY(3)) u_b (
        .E(E), .RESET(RESET), .ADDR(ADDR), .RnW(RnW), .BA(BA), .BS(BS), .DATA_IN(DATA_IN),
        .DATA_OUT(b_dout), .DATA_OE(b_doe), .PPAGE(b_pp), .IO_SEL(b_io),
        .nWR_PHYS(b_nwr), .nFIRQ(b_nfirq), .USER(b_user)
    );

    always #5 E = ~E;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_en[k] = 0; m_prot[k] = 0; m_irq[k] = 0; m_u[k] = 0; m_fault[k] = 0;
            m_akey[k] = 0; m_tkey[k] = 0; m_fa[k] = 0; m_ft[k] = 0; m_fc[k] = 0; m_due[k] = -1;
        end
    endtask

    task automatic model_eval(input int k);
        logic [7:0] ent;
        int page, tsk, n;
        bit hw;
        x_vec = !BA && BS && RnW;
        hw = !m_en[k] || !m_u[k] || !m_prot[k];
        page = int'(ADDR) / 8192;
        tsk = (m_u[k] && !x_vec) ? m_tkey[k] : 0;
        ent = mm[k][tsk * 8 + page];
        n = int'(ADDR) - 'hFE10;
        x_io[k]  = 32'(hw && ADDR >= 16'hFC00 && ADDR <= 16'hFEFF);
        x_reg[k] = 32'(hw && ADDR >= 16'hFE10 && ADDR <= 16'hFE17);
        x_map[k] = 32'(hw && ADDR >= 16'hFE20 && ADDR <= 16'hFE27);
        x_pp[k]  = m_en[k] ? 32'(ent[6:0]) : 32'(page);
        x_wp[k]  = 32'(m_en[k] && m_u[k] && !x_vec && ent[7] === 1'b1 && !RnW && x_io[k] == 0);
        x_nwr[k] = 32'(RnW || x_wp[k] != 0);
        x_doe[k] = 32'(RnW && (x_reg[k] != 0 || x_map[k] != 0));
        x_nfirq[k] = 32'(!(m_fault[k] && m_irq[k]));
        x_user[k]  = 32'(m_u[k]);
        if (x_reg[k] != 0)
            x_dout[k] = n == 0 ? 32'({m_fault[k], !m_u[k], m_irq[k], m_prot[k], m_en[k]}) :
                        n == 1 ? m_akey[k] : n == 2 ? m_tkey[k] : n == 3 ? 'h3B :
                        n == 4 ? m_fa[k] : n == 5 ? m_ft[k] : n == 6 ? m_fc[k] : 0;
        else if (x_map[k] != 0)
            x_dout[k] = 32'(mm[k][m_akey[k] * 8 + int'(ADDR) - 'hFE20]);
        else
            x_dout[k] = 0;
    endtask

    task automatic model_step(input int k);
        int n;
        bit wrr, clr;
        n = int'(ADDR) - 'hFE10;
        wrr = x_reg[k] != 0 && !RnW;
        clr = wrr && n == 4;
        if (x_map[k] != 0 && !RnW)
            mm[k][m_akey[k] * 8 + int'(ADDR) - 'hFE20] = DATA_IN;
        if (x_wp[k] != 0) begin
            m_fc[k] = m_fc[k] < 255 ? m_fc[k] + 1 : 255;
            if (!m_fault[k] || clr) begin
                m_fault[k] = 1; m_fa[k] = int'(ADDR) / 256; m_ft[k] = m_tkey[k];
            end
        end else if (clr) begin
            m_fault[k] = 0; m_fa[k] = 0; m_ft[k] = 0;
        end
        if (wrr && n == 6) m_fc[k] = 0;
        // Switch modelled as an absolute deadline edge rather than a countdown.
        if (x_vec) begin
            m_u[k] = 0; m_due[k] = -1;
        end else if (x_reg[k] != 0 && RnW && n == 3 && !m_u[k]) begin
            if (dly[k] == 0) m_u[k] = 1;
            else m_due[k] = edge_no + dly[k];
        end else if (m_due[k] == edge_no) begin
            m_u[k] = 1; m_due[k] = -1;
        end
        if (wrr && n == 0) begin
            m_en[k] = DATA_IN[0]; m_prot[k] = DATA_IN[1]; m_irq[k] = DATA_IN[2];
        end
        if (wrr && n == 1) m_akey[k] = int'(DATA_IN) % 32;
        if (wrr && n == 2) m_tkey[k] = int'(DATA_IN) % 32;
    endtask

    task automatic cyc(input logic [15:0] a, input logic rnw, input logic ba, input logic bs,
                       input logic [7:0] d);
        ADDR = a; RnW = rnw; BA = ba; BS = bs; DATA_IN = d;
        @(posedge E);
        #2;
        o_pp = '{32'(a_pp), 32'(b_pp)};       o_io = '{32'(a_io), 32'(b_io)};
        o_nwr = '{32'(a_nwr), 32'(b_nwr)};    o_doe = '{32'(a_doe), 32'(b_doe)};
        o_dout = '{32'(a_dout), 32'(b_dout)}; o_nfirq = '{32'(a_nfirq), 32'(b_nfirq)};
        o_user = '{32'(a_user), 32'(b_user)};
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            chk($sformatf("ppage%0d@%h", k, a), o_pp[k], x_pp[k]);
            chk($sformatf("io_sel%0d@%h", k, a), o_io[k], x_io[k]);
            chk($sformatf("nwr%0d@%h", k, a), o_nwr[k], x_nwr[k]);
            chk($sformatf("data_oe%0d@%h", k, a), o_doe[k], x_doe[k]);
            if (x_doe[k] != 0) chk($sformatf("data_out%0d@%h", k, a), o_dout[k], x_dout[k]);
            chk($sformatf("nfirq%0d@%h", k, a), o_nfirq[k], x_nfirq[k]);
            chk($sformatf("user%0d@%h", k, a), o_user[k], x_user[k]);
        end
        @(negedge E);
        for (int k = 0; k < 2; k++) model_step(k);
        edge_no++;
        #1;
    endtask

    task automatic rd(input logic [15:0] a);
        cyc(a, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(a, 1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic vec_fetch();
        cyc(16'hFFFE, 1'b1, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        model_reset();
        #2;
        chk("rst_oe_a", 32'(a_doe), 0);     chk("rst_nfirq_a", 32'(a_nfirq), 1);
        chk("rst_user_a", 32'(a_user), 0);  chk("rst_nwr_a", 32'(a_nwr), 1);
        chk("rst_user_b", 32'(b_user), 0);  chk("rst_nfirq_b", 32'(b_nfirq), 1);
        @(negedge E);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        logic [15:0] a;
        logic        rnw, ba, bs;
        int          r;
        do_reset();
        rd(16'hA123);
        chk("reset_ppage", o_pp[0], 'h05); chk("reset_user", o_user[0], 0);
        chk("reset_oe", o_doe[0], 0);      chk("reset_nfirq", o_nfirq[0], 1);
        rd(16'hFE10);
        chk("reset_ctrl", o_dout[0], 'h08);
        for (int t = 0; t < 32; t++) begin
            wr(16'hFE11, 8'(t));
            for (int i = 0; i < 8; i++) wr(16'hFE20 + 16'(i), 8'($urandom));
        end
        wr(16'hFE11, 8'h03); wr(16'hFE25, 8'h4C); wr(16'hFE22, 8'h91);
        wr(16'hFE10, 8'h01); wr(16'hFE12, 8'h03);
        rd(16'hFE13);
        chk("rti_value", o_dout[0], 'h3B);
        rd(16'h0000);
        rd(16'hA000);
        chk("switch_user", o_user[0], 1); chk("task3_ppage", o_pp[0], 'h4C);
        wr(16'hFE10, 8'h05);
        wr(16'h4567, 8'hAA);
        chk("wp_nwr", o_nwr[0], 1);
        rd(16'hFE14); chk("fault_addr", o_dout[0], 'h45);
        rd(16'hFE15); chk("fault_task", o_dout[0], 'h03);
        rd(16'hFE16); chk("fault_cnt1", o_dout[0], 'h01); chk("firq_low", o_nfirq[0], 0);
        wr(16'h5000, 8'h11);
        rd(16'hFE14); chk("fault_sticky", o_dout[0], 'h45);
        rd(16'hFE16); chk("fault_cnt2", o_dout[0], 'h02);
        wr(16'hFE14, 8'h00);
        rd(16'h0000); chk("firq_clear", o_nfirq[0], 1);
        wr(16'hFE10, 8'h07);
        wr(16'hFE10, 8'h00);
        rd(16'hFE10); chk("locked_oe", o_doe[0], 0);
        rd(16'hA000); chk("locked_ppage", o_pp[0], 'h4C);
        vec_fetch(); chk("vector_ppage", o_pp[0], 32'(mm[0][7][6:0]));
        rd(16'h0000); chk("vector_user", o_user[0], 0);
        rd(16'hFE13);
        rd(16'h0000); chk("d3_cancel_e1", o_user[1], 0);
        vec_fetch();  chk("d3_cancel_e2", o_user[1], 0);
        for (int i = 0; i < 4; i++) begin
            rd(16'h0000); chk("d3_cancel_after", o_user[1], 0);
        end
        rd(16'hFE13);
        rd(16'h0000); chk("d3_edge1", o_user[1], 0);
        rd(16'h0000); chk("d3_edge2", o_user[1], 0);
        rd(16'h0000); chk("d3_edge3", o_user[1], 0);
        rd(16'h0000); chk("d3_rise", o_user[1], 1);
        vec_fetch();
        wr(16'hFE10, 8'h05);
        rd(16'hFE13);
        for (int i = 0; i < 4; i++) rd(16'h0000);
        wr(16'hFE16, 8'h00);
        for (int i = 0; i < 300; i++) wr(16'h4567, 8'(i));
        rd(16'hFE16); chk("sat_a", o_dout[0], 'hFF); chk("sat_b", o_dout[1], 'hFF);
        vec_fetch();
        rd(16'hFE13);
        rd(16'h0000);
        do_reset();
        rd(16'hFE16); chk("rst_cnt_a", o_dout[0], 0); chk("rst_cnt_b", o_dout[1], 0);
        for (int i = 0; i < 4; i++) begin
            rd(16'h0000); chk("rst_cancel_b", o_user[1], 0);
        end
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(0, 99));
            a = r < 35 ? 16'hFE10 + 16'($urandom_range(0, 7)) :
                r < 55 ? 16'hFE20 + 16'($urandom_range(0, 7)) :
                r < 62 ? 16'hFC00 + 16'($urandom_range(0, 'h2FF)) : 16'($urandom);
            rnw = 1'($urandom);
            ba = 1'($urandom);
            bs = ba ? 1'($urandom) : 1'b0;
            if ($urandom_range(0, 19) == 0) begin
                rnw = 1'b1; ba = 1'b0; bs = 1'b1;
            end
            cyc(a, rnw, ba, bs, 8'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
